// File: rtl/fsm_seq_pkg.sv
// Shared definitions for the sequence generator: mode and state encodings,
// external mode decode and the start value of each sequence mode.
package fsm_seq_pkg;

    localparam int unsigned MAX_WIDTH = 16;

    typedef enum logic [2:0] {
        MODE_UP      = 3'd0,
        MODE_DOWN    = 3'd1,
        MODE_GRAY    = 3'd2,
        MODE_JOHNSON = 3'd3,
        MODE_RING    = 3'd4
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

    // Reserved encodings 5..7 behave as binary up.
    function automatic mode_e decode_mode(input logic [2:0] m);
        case (m)
            3'd1:    return MODE_DOWN;
            3'd2:    return MODE_GRAY;
            3'd3:    return MODE_JOHNSON;
            3'd4:    return MODE_RING;
            default: return MODE_UP;
        endcase
    endfunction

    // Start value of the internal counter, right-aligned in MAX_WIDTH bits.
    function automatic logic [MAX_WIDTH-1:0] start_value(input mode_e m, input int unsigned width);
        case (m)
            MODE_DOWN: return {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - width);
            MODE_RING: return {{(MAX_WIDTH-1){1'b0}}, 1'b1};
            default:   return '0;
        endcase
    endfunction

endpackage

// File: rtl/fsm_seq_gen_if.sv
// Control/data bundle of the sequence generator.
//   oe       advance enable
//   mode     requested sequence mode
//   load     synchronous parallel load (wins over oe)
//   load_val value for load
//   out      current code (registered)
//   valid    high while running
//   wrap     one-cycle pulse when the sequence returns to its start
interface fsm_seq_gen_if #(
    parameter int unsigned WIDTH = 3
);
    logic             oe;
    logic [2:0]       mode;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] out;
    logic             valid;
    logic             wrap;

    modport master (output oe, mode, load, load_val, input out, valid, wrap);
    modport slave  (input oe, mode, load, load_val, output out, valid, wrap);
endinterface

// File: rtl/fsm_seq_next.sv
// Combinational step function of the sequence generator.
//   seq      current internal counter value
//   mode_r   active (sampled) mode
//   seq_next counter value after one step
//   is_last  current value is the last one before the sequence restarts
module fsm_seq_next
    import fsm_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 3
) (
    input  logic [WIDTH-1:0] seq,
    input  mode_e            mode_r,
    output logic [WIDTH-1:0] seq_next,
    output logic             is_last
);
    localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

    always_comb begin
        // Up and Gray share the plain binary counter.
        seq_next = seq + WIDTH'(1);
        is_last  = &seq;
        case (mode_r)
            MODE_DOWN: begin
                seq_next = seq - WIDTH'(1);
                is_last  = (seq == '0);
            end
            MODE_JOHNSON: begin
                seq_next = {seq[WIDTH-2:0], ~seq[WIDTH-1]};
                is_last  = (seq == MSB_ONLY);
            end
            MODE_RING: begin
                seq_next = {seq[WIDTH-2:0], seq[WIDTH-1]};
                is_last  = seq[WIDTH-1];
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/fsm_seq_gen.sv
// Parametrised sequence generator: IDLE/RUN/HOLD control FSM with five
// sequence modes, synchronous parallel load and a registered wrap pulse.
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  fsm_seq_gen_if slave port (oe, mode, load, load_val / out, valid, wrap)
module fsm_seq_gen
    import fsm_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 3
) (
    input  logic         clk,
    input  logic         rst,
    fsm_seq_gen_if.slave bus
);
    state_e           state, state_n;
    mode_e            mode_r, mode_n, mode_in;
    logic [WIDTH-1:0] seq, seq_n, out_q, out_n;
    logic             valid_q, valid_n, wrap_q, wrap_n;
    logic [WIDTH-1:0] step_seq, start_in, load_seq, lv_inv;
    logic             is_last, johnson_ok;

    function automatic logic [WIDTH-1:0] code_of(input logic [WIDTH-1:0] s, input mode_e m);
        return (m == MODE_GRAY) ? (s ^ (s >> 1)) : s;
    endfunction

    fsm_seq_next #(.WIDTH(WIDTH)) u_next (
        .seq      (seq),
        .mode_r   (mode_r),
        .seq_next (step_seq),
        .is_last  (is_last)
    );

    assign mode_in  = decode_mode(bus.mode);
    assign start_in = WIDTH'(start_value(mode_in, WIDTH));
    assign lv_inv   = ~bus.load_val;

    // Legal Johnson codes are ones-runs anchored at bit 0 (0..01..1) or at
    // the MSB (1..10..0); all-zero falls into the first form.
    assign johnson_ok = ((bus.load_val & (bus.load_val + WIDTH'(1))) == '0) ||
                        ((lv_inv & (lv_inv + WIDTH'(1))) == '0);

    always_comb begin
        load_seq = bus.load_val;
        case (mode_in)
            MODE_RING:    if (!$onehot(bus.load_val)) load_seq = WIDTH'(1);
            MODE_JOHNSON: if (!johnson_ok) load_seq = '0;
            default: ;
        endcase
    end

    always_comb begin
        state_n = state;
        seq_n   = seq;
        mode_n  = mode_r;
        wrap_n  = 1'b0;
        if (bus.load) begin
            state_n = HOLD;
            seq_n   = load_seq;
            mode_n  = mode_in;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.oe) begin
                        state_n = RUN;
                        mode_n  = mode_in;
                        seq_n   = start_in;
                    end
                end
                RUN, HOLD: begin
                    if (bus.oe) begin
                        state_n = RUN;
                        if (is_last) begin
                            // Restart in the newly sampled mode; with an
                            // unchanged mode this equals the normal step.
                            wrap_n = 1'b1;
                            mode_n = mode_in;
                            seq_n  = start_in;
                        end else begin
                            seq_n  = step_seq;
                        end
                    end else begin
                        state_n = HOLD;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
        out_n   = (state_n == IDLE) ? '0 : code_of(seq_n, mode_n);
        valid_n = (state_n == RUN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            seq     <= '0;
            mode_r  <= MODE_UP;
            out_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state   <= state_n;
            seq     <= seq_n;
            mode_r  <= mode_n;
            out_q   <= out_n;
            valid_q <= valid_n;
            wrap_q  <= wrap_n;
        end
    end

    assign bus.out   = out_q;
    assign bus.valid = valid_q;
    assign bus.wrap  = wrap_q;
endmodule

// File: doc/fsm_seq_gen.md
# fsm_seq_gen

Parametrised sequence-generator FSM: the next generation of the team's 3-bit `oe`-stepped FSM, generalised to `WIDTH` bits with five selectable sequence modes. It adds a synchronous parallel load, hold/pause, and a registered wrap pulse. It sits in the control path as a stepping source for sequencers, LED/scan drivers and bench stimulus. It advances one code per clock while `oe` is high.

## Interface
- `WIDTH`, 3, output code width; legal 2..16.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `oe`  in  1  advance enable; 1 = step sequence this cycle.
- `mode`  in  3  sequence mode, sampled only at mode-sample points.
- `load`  in  1  synchronous parallel load, priority over `oe`.
- `load_val`  in  WIDTH  value for `load`.
- `out`  out  WIDTH  current code, registered.
- `valid`  out  1  high while in RUN.
- `wrap`  out  1  one-cycle pulse when `out` returns to the mode start value by stepping.

## Operation
- Modes (`mode_r`):
  - 0 binary up, start 0.
  - 1 binary down, start all-ones.
  - 2 Gray up, start 0. Internal binary counter `seq`; `out = seq ^ (seq >> 1)`.
  - 3 Johnson, start 0, 2·WIDTH states, shift left inserting `~seq[MSB]` (WIDTH=3: 000,001,011,111,110,100,000).
  - 4 one-hot ring, start 1, rotate left.
  - 5–7 reserved, decoded as mode 0.
- States: IDLE, RUN, HOLD.
  - IDLE: `out`=0, `valid`=0. `oe`=1 → RUN; sample `mode`; `out` ← start value; `wrap`=0.
  - RUN: `oe`=1 → step. `oe`=0 → HOLD, `out` frozen.
  - HOLD: `out` frozen, `valid`=0. `oe`=1 → RUN and step in the same cycle.
- Load (any state):
  - `seq` ← `load_val`, `mode` sampled, next state HOLD, `wrap`=0.
  - Sanitising: in ring mode, a value that is not one-hot loads 1. In Johnson mode, a value that is not a legal Johnson code (single contiguous run of ones touching bit 0 or the MSB, or all-0) loads 0. Binary and Gray take the value verbatim; Gray loads the binary `seq`.
- Mode sampling happens only in IDLE→RUN, on `load`, and on the cycle `wrap` is generated, where the new mode is applied to the following step. A mid-sequence `mode` change is otherwise ignored, so illegal Johnson/ring states are never reached.
- Wrap: asserted on the cycle after the step that moves last→start:
  - Up and Gray: all-ones→0.
  - Down: 0→all-ones.
  - Johnson: MSB-only→0.
  - Ring: MSB-set→1.
- Simultaneous `load` and `oe`: load wins; no step.
- Arithmetic: modulo 2^WIDTH; no carry-out port.

## Timing
- Reset, asynchronous on `rst`=0: state IDLE, `seq`=0, `mode_r`=0, `out`=0, `valid`=0, `wrap`=0. Release is synchronous to `clk`, after which the block sits in IDLE.
- Reset mid-sequence discards the current code immediately, without waiting for a clock edge.
- Latency: `out`, `valid` and `wrap` all update on the same rising edge that samples `oe`/`load`. There is one cycle from input to output and no combinational input→output path.
- `wrap` is never asserted for two consecutive cycles unless the sequence period is 1, which is impossible for WIDTH≥2.

## Structure
- Package `fsm_seq_pkg`:
  - mode encodings (`MODE_UP`, `MODE_DOWN`, `MODE_GRAY`, `MODE_JOHNSON`, `MODE_RING`);
  - state encoding (IDLE/RUN/HOLD);
  - a function giving the start value per mode.
- Sub-module `fsm_seq_next`, purely combinational, takes `seq`, `mode_r` and `WIDTH` and returns the next `seq` plus an `is_last` flag.
- The top level holds the state register, load sanitising, mode sampling and output registers.

## Test plan
All with WIDTH=3.
- Reset then `oe`=1 for 9 cycles in mode 0 → `out` 0,1,…,7,0; `wrap` high on the cycle `out` returns to 0; `valid`=1 throughout.
- Mode 3, `oe`=1 for 7 cycles → 000,001,011,111,110,100,000 with `wrap` on the second 000. Then mode 4 with `load` 3'b101 → `out`=001, HOLD.
- Mode 2, 8 steps → 000,001,011,010,110,111,101,100. `mode` changed to 1 mid-sequence → ignored until wrap; next step after wrap is down from 111.
- In RUN, drop `oe` for 3 cycles → `out` frozen, `valid`=0. Re-raise `oe` → steps on the first cycle.
- `load`=1 with `oe`=1, mode 0, `load_val`=5 → `out`=5, no step, `wrap`=0. Next `oe` → 6.
- Assert `rst`=0 between clock edges while `out`=6 → `out`, `valid` and `wrap` go to 0 immediately. After release, the first `oe` yields start value 0.
